// File: rtl/game_state_controller.sv
// Game state controller: IDLE -> GAME -> WIN/LOSE -> IDLE sequencing,
// button press edge detection, post-game dwell timer and a win-screen
// animation frame counter.
module game_state_controller #(
  parameter int DWELL_FRAMES = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  BTNS,
  input  logic        FRAME_TICK,
  input  logic        TARGET_REACHED,
  input  logic        SNAKE_DEAD,
  output logic [1:0]  MSM_State,
  output logic [15:0] FrameCount,
  output logic        GAME_RESET
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GAME = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } state_t;

  localparam logic [7:0] DWELL_MAX = 8'(DWELL_FRAMES);

  state_t      state_reg, state_next;
  logic [3:0]  btns_reg;
  logic [3:0]  btn_rise;
  logic        press;
  logic [7:0]  dwell_reg, dwell_next;
  logic [15:0] frame_reg, frame_next;
  logic        game_reset_reg, game_reset_next;
  logic        dwell_done;
  logic        in_end;
  logic        enter_end;
  logic        enter_win;

  // Per-button rising edge against the previous-cycle copy of BTNS.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rise
      assign btn_rise[gi] = BTNS[gi] & ~btns_reg[gi];
    end
  endgenerate

  assign press      = |btn_rise;
  assign dwell_done = (dwell_reg == DWELL_MAX);
  assign in_end     = (state_reg == ST_WIN) || (state_reg == ST_LOSE);

  // Next-state selection; death outranks target, and both are masked
  // during the first GAME cycle so stale levels from the last game are ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (press) state_next = ST_GAME;
      end
      ST_GAME: begin
        if (!game_reset_reg) begin
          if (SNAKE_DEAD)          state_next = ST_LOSE;
          else if (TARGET_REACHED) state_next = ST_WIN;
        end
      end
      ST_WIN, ST_LOSE: begin
        // Early presses are simply dropped; only a press after the dwell counts.
        if (press && dwell_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath next values: game-reset pulse, dwell timer and win-screen counter.
  always_comb begin
    game_reset_next = (state_next == ST_GAME) && (state_reg != ST_GAME);
    enter_end       = (state_reg == ST_GAME) &&
                      ((state_next == ST_WIN) || (state_next == ST_LOSE));
    enter_win       = (state_reg == ST_GAME) && (state_next == ST_WIN);

    dwell_next = dwell_reg;
    if (enter_end)
      dwell_next = 8'd0;
    else if (in_end && FRAME_TICK && !dwell_done)
      dwell_next = dwell_reg + 8'd1;

    // Clear on entry wins over a coincident tick; wraps naturally at 16 bits.
    frame_next = frame_reg;
    if (enter_win)
      frame_next = 16'd0;
    else if ((state_reg == ST_WIN) && FRAME_TICK)
      frame_next = frame_reg + 16'd1;
  end

  // State and datapath registers; button copy resets high so held buttons
  // do not register as a press when reset releases.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      btns_reg       <= 4'hF;
      dwell_reg      <= 8'd0;
      frame_reg      <= 16'd0;
      game_reset_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      btns_reg       <= BTNS;
      dwell_reg      <= dwell_next;
      frame_reg      <= frame_next;
      game_reset_reg <= game_reset_next;
    end
  end

  assign MSM_State  = state_reg;
  assign FrameCount = frame_reg;
  assign GAME_RESET = game_reset_reg;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: reset/held buttons, game start,
// simultaneous death+target, dwell boundary, win frame counter and wrap,
// asynchronous reset in WIN.
module tb_game_state_controller;

  logic        CLK;
  logic        RESET;
  logic [3:0]  BTNS;
  logic        FRAME_TICK;
  logic        TARGET_REACHED;
  logic        SNAKE_DEAD;
  logic [1:0]  MSM_State;
  logic [15:0] FrameCount;
  logic        GAME_RESET;

  int n_cmp;
  int n_bad;

  game_state_controller #(.DWELL_FRAMES(120)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .BTNS          (BTNS),
    .FRAME_TICK    (FRAME_TICK),
    .TARGET_REACHED(TARGET_REACHED),
    .SNAKE_DEAD    (SNAKE_DEAD),
    .MSM_State     (MSM_State),
    .FrameCount    (FrameCount),
    .GAME_RESET    (GAME_RESET)
  );

  // 100 MHz clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock edge and settle just after it.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; BTNS = 4'b0001; FRAME_TICK = 1'b0;
    TARGET_REACHED = 1'b0; SNAKE_DEAD = 1'b0;
    cyc();
    $display("[tb] reset asserted with U held: state=%b fc=%h gr=%b", MSM_State, FrameCount, GAME_RESET);
    n_cmp++;
    if (MSM_State !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", MSM_State); end
    n_cmp++;
    if (FrameCount !== 16'h0000) begin n_bad++; $display("FAIL reset_fc: got %h want 0000", FrameCount); end
    n_cmp++;
    if (GAME_RESET !== 1'b0) begin n_bad++; $display("FAIL reset_gr: got %b want 0", GAME_RESET); end
    RESET = 1'b0;
    cyc(); cyc();
    $display("[tb] reset released, U still held: state=%b", MSM_State);
    n_cmp++;
    if (MSM_State !== 2'b00) begin n_bad++; $display("FAIL held_btn_no_press: got %b want 00", MSM_State); end
  endtask

  task automatic test_start();
    BTNS = 4'b0000;
    cyc();
    BTNS = 4'b0001;
    cyc();
    $display("[tb] press U: state=%b gr=%b", MSM_State, GAME_RESET);
    n_cmp++;
    if (MSM_State !== 2'b01) begin n_bad++; $display("FAIL start_state: got %b want 01", MSM_State); end
    n_cmp++;
    if (GAME_RESET !== 1'b1) begin n_bad++; $display("FAIL start_gr_high: got %b want 1", GAME_RESET); end
    BTNS = 4'b0000;
    cyc();
    $display("[tb] game cycle 2: state=%b gr=%b", MSM_State, GAME_RESET);
    n_cmp++;
    if (GAME_RESET !== 1'b0) begin n_bad++; $display("FAIL start_gr_one_cycle: got %b want 0", GAME_RESET); end
    BTNS = 4'b0100;
    cyc();
    $display("[tb] press in GAME: state=%b", MSM_State);
    n_cmp++;
    if (MSM_State !== 2'b01) begin n_bad++; $display("FAIL game_press_ignored: got %b want 01", MSM_State); end
    BTNS = 4'b0000;
    cyc();
  endtask

  task automatic test_both_lose();
    TARGET_REACHED = 1'b1; SNAKE_DEAD = 1'b1;
    cyc();
    TARGET_REACHED = 1'b0; SNAKE_DEAD = 1'b0;
    $display("[tb] dead+target together: state=%b fc=%h", MSM_State, FrameCount);
    n_cmp++;
    if (MSM_State !== 2'b11) begin n_bad++; $display("FAIL both_select_lose: got %b want 11", MSM_State); end
    n_cmp++;
    if (FrameCount !== 16'h0000) begin n_bad++; $display("FAIL lose_fc_unchanged: got %h want 0000", FrameCount); end
  endtask

  task automatic test_dwell();
    FRAME_TICK = 1'b1;
    repeat (119) cyc();
    FRAME_TICK = 1'b0;
    BTNS = 4'b1000;
    cyc();
    $display("[tb] press after 119 ticks: state=%b", MSM_State);
    n_cmp++;
    if (MSM_State !== 2'b11) begin n_bad++; $display("FAIL dwell_early_press: got %b want 11", MSM_State); end
    BTNS = 4'b0000;
    cyc();
    // 120th tick plus five beyond: counter must saturate at 120.
    FRAME_TICK = 1'b1;
    repeat (6) cyc();
    FRAME_TICK = 1'b0;
    n_cmp++;
    if (MSM_State !== 2'b11) begin n_bad++; $display("FAIL dwell_no_self_exit: got %b want 11", MSM_State); end
    BTNS = 4'b0010;
    cyc();
    $display("[tb] press after dwell: state=%b", MSM_State);
    n_cmp++;
    if (MSM_State !== 2'b00) begin n_bad++; $display("FAIL dwell_exit_idle: got %b want 00", MSM_State); end
    BTNS = 4'b0000;
    cyc();
  endtask

  task automatic test_win_count();
    BTNS = 4'b0001;
    cyc();
    BTNS = 4'b0000;
    cyc();
    TARGET_REACHED = 1'b1;
    cyc();
    TARGET_REACHED = 1'b0;
    $display("[tb] target reached: state=%b fc=%h", MSM_State, FrameCount);
    n_cmp++;
    if (MSM_State !== 2'b10) begin n_bad++; $display("FAIL win_state: got %b want 10", MSM_State); end
    FRAME_TICK = 1'b1;
    repeat (300) cyc();
    FRAME_TICK = 1'b0;
    $display("[tb] 300 ticks in WIN: fc=%h", FrameCount);
    n_cmp++;
    if (FrameCount !== 16'h012C) begin n_bad++; $display("FAIL win_fc_300: got %h want 012c", FrameCount); end
    BTNS = 4'b0001;
    cyc();
    BTNS = 4'b0000;
    $display("[tb] press after WIN dwell: state=%b fc=%h", MSM_State, FrameCount);
    n_cmp++;
    if (MSM_State !== 2'b00) begin n_bad++; $display("FAIL win_exit_idle: got %b want 00", MSM_State); end
    FRAME_TICK = 1'b1;
    cyc();
    FRAME_TICK = 1'b0;
    n_cmp++;
    if (FrameCount !== 16'h012C) begin n_bad++; $display("FAIL idle_fc_hold: got %h want 012c", FrameCount); end
  endtask

  task automatic test_stale_target_wrap();
    TARGET_REACHED = 1'b1; FRAME_TICK = 1'b1; BTNS = 4'b0001;
    cyc();
    $display("[tb] start with target held: state=%b gr=%b fc=%h", MSM_State, GAME_RESET, FrameCount);
    n_cmp++;
    if (MSM_State !== 2'b01 || GAME_RESET !== 1'b1) begin
      n_bad++; $display("FAIL stale_start: got state=%b gr=%b want 01/1", MSM_State, GAME_RESET);
    end
    BTNS = 4'b0000;
    cyc();
    n_cmp++;
    if (MSM_State !== 2'b01 || GAME_RESET !== 1'b0) begin
      n_bad++; $display("FAIL stale_masked: got state=%b gr=%b want 01/0", MSM_State, GAME_RESET);
    end
    n_cmp++;
    if (FrameCount !== 16'h012C) begin n_bad++; $display("FAIL game_fc_hold: got %h want 012c", FrameCount); end
    cyc();
    TARGET_REACHED = 1'b0;
    $display("[tb] WIN entry with coincident tick: state=%b fc=%h", MSM_State, FrameCount);
    n_cmp++;
    if (MSM_State !== 2'b10) begin n_bad++; $display("FAIL stale_win_next: got %b want 10", MSM_State); end
    n_cmp++;
    if (FrameCount !== 16'h0000) begin n_bad++; $display("FAIL win_entry_clear: got %h want 0000", FrameCount); end
    repeat (65535) cyc();
    $display("[tb] 65535 ticks: fc=%h", FrameCount);
    n_cmp++;
    if (FrameCount !== 16'hFFFF) begin n_bad++; $display("FAIL fc_ffff: got %h want ffff", FrameCount); end
    cyc();
    $display("[tb] 65536 ticks: fc=%h", FrameCount);
    n_cmp++;
    if (FrameCount !== 16'h0000) begin n_bad++; $display("FAIL fc_wrap: got %h want 0000", FrameCount); end
    repeat (500) cyc();
    FRAME_TICK = 1'b0;
    n_cmp++;
    if (FrameCount !== 16'h01F4) begin n_bad++; $display("FAIL fc_500: got %h want 01f4", FrameCount); end
  endtask

  task automatic test_async_reset();
    #2;
    RESET = 1'b1;
    #1;
    $display("[tb] async reset between edges: state=%b fc=%h gr=%b", MSM_State, FrameCount, GAME_RESET);
    n_cmp++;
    if (MSM_State !== 2'b00) begin n_bad++; $display("FAIL async_state: got %b want 00", MSM_State); end
    n_cmp++;
    if (FrameCount !== 16'h0000) begin n_bad++; $display("FAIL async_fc: got %h want 0000", FrameCount); end
    n_cmp++;
    if (GAME_RESET !== 1'b0) begin n_bad++; $display("FAIL async_gr: got %b want 0", GAME_RESET); end
    cyc();
    RESET = 1'b0;
    cyc();
    n_cmp++;
    if (MSM_State !== 2'b00) begin n_bad++; $display("FAIL post_reset_idle: got %b want 00", MSM_State); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_start();
    test_both_lose();
    test_dwell();
    test_win_count();
    test_stale_target_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
